// File: rtl/dram_responder_pkg.sv
// Shared types for the DRAM responder: AXI response and burst encodings,
// write/read FSM state enums and the beat-to-beat index step.
package dram_responder_pkg;

   typedef enum logic [1:0] {
      RespOkay   = 2'b00,
      RespSlverr = 2'b10
   } resp_e;

   typedef enum logic [1:0] {
      BurstFixed = 2'b00,
      BurstIncr  = 2'b01,
      BurstWrap  = 2'b10
   } burst_e;

   typedef enum logic [1:0] {
      WIdle,
      WData,
      WResp
   } w_state_e;

   typedef enum logic [1:0] {
      RIdle,
      RWait,
      RData
   } r_state_e;

   // Callers truncate to the memory index width, so the +1 wraps modulo MemWords.
   function automatic logic [31:0] next_index(input logic [31:0] index, input burst_e burst);
      return (burst == BurstFixed) ? index : index + 32'd1;
   endfunction

endpackage

// File: rtl/dram_responder_mem.sv
// Byte-strobed register-file backing store for the DRAM responder.
// Ports:
//   i_clk    - clock
//   i_we     - write enable; strobed bytes of i_wdata land at i_waddr on the edge
//   i_waddr  - write word index
//   i_wdata  - write data
//   i_wstrb  - byte enables
//   i_raddr  - read word index
//   o_rdata  - combinational read data (pre-edge contents)
module dram_responder_mem #(
   parameter int unsigned DataWidth = 64,
   parameter int unsigned MemWords  = 1024,
   localparam int unsigned IdxW     = $clog2(MemWords),
   localparam int unsigned StrbW    = DataWidth / 8
) (
   input  logic                 i_clk,
   input  logic                 i_we,
   input  logic [IdxW-1:0]      i_waddr,
   input  logic [DataWidth-1:0] i_wdata,
   input  logic [StrbW-1:0]     i_wstrb,
   input  logic [IdxW-1:0]      i_raddr,
   output logic [DataWidth-1:0] o_rdata
);

   logic [DataWidth-1:0] r_mem [MemWords];

   // No reset: contents survive ui_clk_sync_rst.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < int'(StrbW); b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dram_axi_responder.sv
// AXI4 slave standing in for the MIG at the DRAM end of the wrapper chain.
// Ports:
//   ui_clk, ui_clk_sync_rst - clock and synchronous active-high reset
//   init_calib_complete     - high once CalibCycles have elapsed after reset
//   s_axi_aw*/w*/b*         - write channels, one transaction outstanding
//   s_axi_ar*/r*            - read channels, independent of the write side
// Illegal requests (WRAP/reserved burst or narrow size) are consumed/produced
// in full with SLVERR and never touch memory; read data for them is zero.
module dram_axi_responder
   import dram_responder_pkg::*;
#(
   parameter int unsigned IdWidth     = 6,
   parameter int unsigned AddrWidth   = 30,
   parameter int unsigned DataWidth   = 64,
   parameter int unsigned MemWords    = 1024,
   parameter int unsigned ReadLatency = 4,
   parameter int unsigned CalibCycles = 16
) (
   input  logic                   ui_clk,
   input  logic                   ui_clk_sync_rst,
   output logic                   init_calib_complete,
   input  logic [IdWidth-1:0]     s_axi_awid,
   input  logic [AddrWidth-1:0]   s_axi_awaddr,
   input  logic [7:0]             s_axi_awlen,
   input  logic [2:0]             s_axi_awsize,
   input  logic [1:0]             s_axi_awburst,
   input  logic                   s_axi_awlock,
   input  logic [3:0]             s_axi_awcache,
   input  logic [2:0]             s_axi_awprot,
   input  logic [3:0]             s_axi_awqos,
   input  logic                   s_axi_awvalid,
   output logic                   s_axi_awready,
   input  logic [DataWidth-1:0]   s_axi_wdata,
   input  logic [DataWidth/8-1:0] s_axi_wstrb,
   input  logic                   s_axi_wlast,
   input  logic                   s_axi_wvalid,
   output logic                   s_axi_wready,
   output logic [IdWidth-1:0]     s_axi_bid,
   output logic [1:0]             s_axi_bresp,
   output logic                   s_axi_bvalid,
   input  logic                   s_axi_bready,
   input  logic [IdWidth-1:0]     s_axi_arid,
   input  logic [AddrWidth-1:0]   s_axi_araddr,
   input  logic [7:0]             s_axi_arlen,
   input  logic [2:0]             s_axi_arsize,
   input  logic [1:0]             s_axi_arburst,
   input  logic                   s_axi_arlock,
   input  logic [3:0]             s_axi_arcache,
   input  logic [2:0]             s_axi_arprot,
   input  logic [3:0]             s_axi_arqos,
   input  logic                   s_axi_arvalid,
   output logic                   s_axi_arready,
   output logic [IdWidth-1:0]     s_axi_rid,
   output logic [DataWidth-1:0]   s_axi_rdata,
   output logic [1:0]             s_axi_rresp,
   output logic                   s_axi_rlast,
   output logic                   s_axi_rvalid,
   input  logic                   s_axi_rready
);

   localparam int unsigned StrbW   = DataWidth / 8;
   localparam int unsigned SizeLog = $clog2(StrbW);
   localparam int unsigned IdxW    = $clog2(MemWords);
   localparam int unsigned CalW    = $clog2(CalibCycles + 2);
   localparam int unsigned LatW    = $clog2(ReadLatency + 1);

   // Sideband and out-of-index address bits are accepted and ignored.
   logic w_unused;
   assign w_unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awaddr,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_araddr};

   // ---------------- calibration ----------------
   logic [CalW-1:0] r_calib_cnt;
   logic            w_calib_done;

   assign w_calib_done        = (r_calib_cnt == CalW'(CalibCycles));
   assign init_calib_complete = w_calib_done;

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         r_calib_cnt <= '0;
      end else if (!w_calib_done) begin
         r_calib_cnt <= r_calib_cnt + CalW'(1);
      end
   end

   // ---------------- write side ----------------
   w_state_e            r_wstate, w_wstate_next;
   logic [IdWidth-1:0]  r_wid;
   logic [IdxW-1:0]     r_widx;
   logic [7:0]          r_wlen, r_wbeat;
   logic [1:0]          r_wburst;
   logic                r_wbad, r_wlast_err;
   logic                w_aw_hs, w_w_hs, w_wbeat_last, w_we, w_aw_bad;

   assign w_aw_bad     = !(s_axi_awburst == BurstFixed || s_axi_awburst == BurstIncr) ||
                         (s_axi_awsize != 3'(SizeLog));
   assign w_aw_hs      = s_axi_awvalid && s_axi_awready;
   assign w_w_hs       = s_axi_wvalid && s_axi_wready;
   assign w_wbeat_last = (r_wbeat == r_wlen);
   // A reset edge abandons the burst, including a beat presented on that edge.
   assign w_we         = w_w_hs && !r_wbad && !ui_clk_sync_rst;

   always_comb begin
      w_wstate_next = r_wstate;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      unique case (r_wstate)
         WIdle: begin
            s_axi_awready = w_calib_done;
            if (s_axi_awvalid && w_calib_done) w_wstate_next = WData;
         end
         WData: begin
            s_axi_wready = 1'b1;
            if (s_axi_wvalid && w_wbeat_last) w_wstate_next = WResp;
         end
         WResp: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_wstate_next = WIdle;
         end
         default: w_wstate_next = WIdle;
      endcase
   end

   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         r_wstate    <= WIdle;
         r_wid       <= '0;
         r_widx      <= '0;
         r_wlen      <= '0;
         r_wbeat     <= '0;
         r_wburst    <= '0;
         r_wbad      <= 1'b0;
         r_wlast_err <= 1'b0;
      end else begin
         r_wstate <= w_wstate_next;
         if (w_aw_hs) begin
            r_wid       <= s_axi_awid;
            r_widx      <= s_axi_awaddr[SizeLog +: IdxW];
            r_wlen      <= s_axi_awlen;
            r_wbeat     <= '0;
            r_wburst    <= s_axi_awburst;
            r_wbad      <= w_aw_bad;
            r_wlast_err <= 1'b0;
         end
         if (w_w_hs) begin
            r_widx  <= IdxW'(next_index(32'(r_widx), burst_e'(r_wburst)));
            r_wbeat <= r_wbeat + 8'd1;
            // awlen alone sets the length; a wrong wlast only taints the response.
            if (s_axi_wlast != w_wbeat_last) r_wlast_err <= 1'b1;
         end
      end
   end

   assign s_axi_bid   = r_wid;
   assign s_axi_bresp = (r_wbad || r_wlast_err) ? RespSlverr : RespOkay;

   // ---------------- read side ----------------
   r_state_e            r_rstate, w_rstate_next;
   logic [IdWidth-1:0]  r_rid;
   logic [IdxW-1:0]     r_ridx;
   logic [7:0]          r_rlen, r_rbeat;
   logic [1:0]          r_rburst;
   logic                r_rbad, r_rlast;
   logic [LatW-1:0]     r_lat_cnt;
   logic [DataWidth-1:0] r_rdata, w_mem_rdata;
   logic                w_ar_hs, w_load, w_ar_bad;

   assign w_ar_bad = !(s_axi_arburst == BurstFixed || s_axi_arburst == BurstIncr) ||
                     (s_axi_arsize != 3'(SizeLog));
   assign w_ar_hs  = s_axi_arvalid && s_axi_arready;

   always_comb begin
      w_rstate_next = r_rstate;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      w_load        = 1'b0;
      unique case (r_rstate)
         RIdle: begin
            s_axi_arready = w_calib_done;
            if (s_axi_arvalid && w_calib_done) w_rstate_next = RWait;
         end
         RWait: begin
            if (r_lat_cnt == '0) begin
               w_load        = 1'b1;
               w_rstate_next = RData;
            end
         end
         RData: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) begin
               if (r_rlast) w_rstate_next = RIdle;
               else         w_load        = 1'b1;
            end
         end
         default: w_rstate_next = RIdle;
      endcase
   end

   // r_ridx/r_rbeat point at the next beat to load into the R register.
   always_ff @(posedge ui_clk) begin
      if (ui_clk_sync_rst) begin
         r_rstate  <= RIdle;
         r_rid     <= '0;
         r_ridx    <= '0;
         r_rlen    <= '0;
         r_rbeat   <= '0;
         r_rburst  <= '0;
         r_rbad    <= 1'b0;
         r_rlast   <= 1'b0;
         r_lat_cnt <= '0;
         r_rdata   <= '0;
      end else begin
         r_rstate <= w_rstate_next;
         if (w_ar_hs) begin
            r_rid     <= s_axi_arid;
            r_ridx    <= s_axi_araddr[SizeLog +: IdxW];
            r_rlen    <= s_axi_arlen;
            r_rbeat   <= '0;
            r_rburst  <= s_axi_arburst;
            r_rbad    <= w_ar_bad;
            r_lat_cnt <= LatW'(ReadLatency - 1);
         end
         if (r_rstate == RWait && r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - LatW'(1);
         if (w_load) begin
            // Memory read is combinational on pre-edge contents: old data wins over
            // a write committing on the same edge.
            r_rdata <= r_rbad ? '0 : w_mem_rdata;
            r_rlast <= (r_rbeat == r_rlen);
            r_ridx  <= IdxW'(next_index(32'(r_ridx), burst_e'(r_rburst)));
            r_rbeat <= r_rbeat + 8'd1;
         end
      end
   end

   assign s_axi_rid   = r_rid;
   assign s_axi_rdata = r_rdata;
   assign s_axi_rresp = r_rbad ? RespSlverr : RespOkay;
   assign s_axi_rlast = r_rlast;

   dram_responder_mem #(
      .DataWidth (DataWidth),
      .MemWords  (MemWords)
   ) u_mem (
      .i_clk   (ui_clk),
      .i_we    (w_we),
      .i_waddr (r_widx),
      .i_wdata (s_axi_wdata),
      .i_wstrb (s_axi_wstrb),
      .i_raddr (r_ridx),
      .o_rdata (w_mem_rdata)
   );

endmodule

// File: doc/dram_axi_responder.md
Name: dram_axi_responder

Overview:
- Synthesizable AXI4 slave that stands in for the Xilinx MIG at the DRAM end of the DRAM wrapper chain.
- Used in simulation and in FPGA builds without a DRAM PHY.
- Exposes the same flat MIG-style AXI slave port set, a UI clock/reset pair and a calibration-done flag, so the wrapper's ID/address adaptation logic binds to it unchanged.
- Backing store is an internal register-file memory with configurable read latency.

Parameters:
- IdWidth, 6, AXI ID width on s_axi_*id.
- AddrWidth, 30, byte address width.
- DataWidth, 64, AXI data width; power of two, >= 32.
- MemWords, 1024, backing-store depth in DataWidth words; power of two.
- ReadLatency, 4, cycles from AR handshake to first R beat valid; >= 1.
- CalibCycles, 16, cycles after reset release before init_calib_complete rises.

Ports:
- ui_clk  in  1  single clock for all logic.
- ui_clk_sync_rst  in  1  synchronous, active-high reset.
- init_calib_complete  out  1  high once calibration delay has elapsed.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  IdWidth/AddrWidth/8/3/2  write address channel.
- s_axi_awlock/awcache/awprot/awqos  in  1/4/3/4  accepted and ignored.
- s_axi_awvalid in 1; s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast/wvalid  in  DataWidth/DataWidth/8/1/1  write data channel.
- s_axi_wready  out  1  W handshake.
- s_axi_bid/bresp/bvalid  out  IdWidth/2/1  write response.
- s_axi_bready  in  1  B handshake.
- s_axi_arid/araddr/arlen/arsize/arburst  in  as AW  read address channel.
- s_axi_arlock/arcache/arprot/arqos  in  as AW  ignored.
- s_axi_arvalid in 1; s_axi_arready out 1  AR handshake.
- s_axi_rid/rdata/rresp/rlast/rvalid  out  IdWidth/DataWidth/2/1/1  read data channel.
- s_axi_rready  in  1  R handshake.

Behaviour:
- Reset (ui_clk_sync_rst=1 at a ui_clk edge):
  - All FSMs return to IDLE; calib counter clears; every output is 0 (bid, rid, rdata, bresp, rresp included).
  - Memory contents are not cleared.
  - Reset mid-burst abandons the burst; no B or R is issued for it.
- Calibration:
  - The counter increments after reset until it reaches CalibCycles, then init_calib_complete=1 and stays high.
  - awready and arready are forced low until then.
- Word index: addr[log2(DataWidth/8) +: log2(MemWords)]. Upper bits alias (wrap); there is no decode error.
- Legal request: burst INCR or FIXED, and size == log2(DataWidth/8). Anything else is a SLVERR transaction: the full burst is still consumed or produced, memory is untouched, and read data is 0.
- Write FSM:
  - W_IDLE: awready=calib_done. On AW handshake, latch id, index, len, burst, error flag → W_DATA.
  - W_DATA: wready=1. Each beat writes the strobed bytes at the current index, committed at the handshake edge. Index advances by +1 for INCR and holds for FIXED, wrapping modulo MemWords. On the beat that is the len+1-th → W_RESP.
  - wlast mismatch: a wlast that does not match the beat count sets SLVERR; the transfer length is governed by awlen only.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY(00) or SLVERR(10). Held stable until bready → W_IDLE.
  - Throughput: one write transaction outstanding; awready stays low outside W_IDLE.
- Read FSM (independent of the write FSM):
  - R_IDLE: arready=calib_done. On AR handshake, latch fields, load latency counter → R_WAIT.
  - R_WAIT: counts ReadLatency-1 cycles, then loads beat 0 into the R register → R_DATA. First rvalid appears exactly ReadLatency cycles after the AR handshake edge.
  - R_DATA: rvalid=1; rid, rdata, rresp and rlast are stable while rvalid && !rready. On handshake, the next beat loads in the same edge, giving back-to-back beats at one per cycle. rlast=1 on beat len. The last handshake → R_IDLE, and arready can accept a new AR in the following cycle.
- Read/write ordering: a read beat loaded in the same cycle as a W commit to the same index returns the old data. The load reads memory before the write.

Decomposition:
- Package dram_responder_pkg holds:
  - the resp_e encoding (OKAY, SLVERR);
  - the burst_e encoding (FIXED, INCR, WRAP);
  - the w_state_e and r_state_e FSM enums;
  - the function next_index(index, burst).
- Sub-module dram_responder_mem: a MemWords x DataWidth byte-strobed register file with one write port and one combinational read port.
- The top level holds the calibration counter and both FSMs.

Test Plan:
- Reset, then immediate AW valid → awready stays 0 for 16 cycles; init_calib_complete rises at cycle 16 and the AW is accepted on the next edge.
- Write INCR len=3, addr 0x100, id 5, full strobes, data A..D; then read the same → bid=5, bresp=00; rvalid exactly 4 cycles after the AR handshake; rdata A,B,C,D back-to-back; rlast on the 4th beat; rid=5.
- Partial strobe: write 0x1122334455667788 with wstrb=0x0F over prior 0 → read returns 0x0000000055667788.
- FIXED burst len=1 to addr 0x40 with data X,Y → a single-beat read at 0x40 returns Y. AW with size=2 → bresp=10 and memory unchanged.
- R backpressure: rready=0 for 5 cycles on beat 1 → rdata/rlast stable, no beat lost. Address 0x2000 aliases to index 0 with MemWords=1024.
- Assert reset in W_DATA after beat 1 of 4 → all outputs 0 next cycle, no bvalid, and a new transaction after calib completes correctly.
